// File: rtl/pipe_ctrl.sv
// pipe_ctrl: ID-stage decoder and hazard unit for the 5-stage, 19-bit-instruction pipeline.
// Decodes IF_ID, stalls against a scoreboard of in-flight writers, resolves transfers in ID.
module pipe_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [18:0] IF_ID_instruction,
  input  logic        C,
  input  logic        Z,
  output logic        mem_write,
  output logic        reg_write,
  output logic        push,
  output logic        pop,
  output logic        alu_use_carry,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_mux,
  output logic [1:0]  reg_write_mux,
  output logic        alu_in_mux,
  output logic        reg_B_mux,
  output logic        select_c,
  output logic        select_z,
  output logic        write_c,
  output logic        write_z,
  output logic        flush,
  output logic        stall
);

  localparam int unsigned SB_DEPTH = 3;
  localparam int unsigned REG_W    = 3;
  localparam int unsigned OP_W     = 3;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_ABS = 2'b10;
  localparam logic [1:0] PC_STK = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_SHF = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  // Scoreboard entry 0 is EX, 1 is MEM, 2 is WB.
  logic [SB_DEPTH-1:0]            r_sb_valid;
  logic [SB_DEPTH-1:0][REG_W-1:0] r_sb_rd;
  logic [SB_DEPTH-1:0]            r_sb_wflag;
  logic                           r_squash;

  logic [OP_W-1:0]  w_major;
  logic [OP_W-1:0]  w_alu_fn;
  logic [OP_W-1:0]  w_sub;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic [REG_W-1:0] w_src_b;
  logic             w_src_a_en;
  logic             w_src_b_en;
  logic             w_is_cond;
  logic             w_taken;

  logic             w_dec_mem_write;
  logic             w_dec_reg_write;
  logic             w_dec_push;
  logic             w_dec_pop;
  logic             w_dec_alu_use_carry;
  logic [OP_W-1:0]  w_dec_alu_op;
  logic [1:0]       w_dec_pc_mux;
  logic [1:0]       w_dec_reg_write_mux;
  logic             w_dec_alu_in_mux;
  logic             w_dec_reg_B_mux;
  logic             w_dec_select_flags;
  logic             w_dec_write_c;
  logic             w_dec_write_z;

  logic             w_transfer;
  logic             w_data_hazard;
  logic             w_flag_hazard;
  logic             w_hazard;
  logic             w_unused;

  assign w_major  = IF_ID_instruction[18:16];
  assign w_alu_fn = IF_ID_instruction[16:14];
  assign w_sub    = IF_ID_instruction[15:13];
  assign w_rd     = IF_ID_instruction[13:11];
  assign w_rs     = IF_ID_instruction[10:8];
  assign w_rt     = IF_ID_instruction[7:5];

  // Immediate and target bits are consumed by the datapath, not here.
  assign w_unused = ^{IF_ID_instruction[4:0], r_sb_wflag[SB_DEPTH-1]};

  // Field decode into the control bundle and the source-register set.
  always_comb begin
    w_dec_mem_write     = 1'b0;
    w_dec_reg_write     = 1'b0;
    w_dec_push          = 1'b0;
    w_dec_pop           = 1'b0;
    w_dec_alu_use_carry = 1'b0;
    w_dec_alu_op        = '0;
    w_dec_pc_mux        = PC_SEQ;
    w_dec_reg_write_mux = WB_ALU;
    w_dec_alu_in_mux    = 1'b0;
    w_dec_reg_B_mux     = 1'b0;
    w_dec_select_flags  = 1'b0;
    w_dec_write_c       = 1'b0;
    w_dec_write_z       = 1'b0;
    w_src_a_en          = 1'b0;
    w_src_b_en          = 1'b0;
    w_src_b             = w_rt;
    w_is_cond           = 1'b0;
    w_taken             = 1'b0;
    case (w_major)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        w_dec_alu_op        = w_alu_fn;
        w_dec_reg_write     = 1'b1;
        w_dec_reg_write_mux = WB_ALU;
        w_dec_alu_use_carry = ~w_alu_fn[2] & w_alu_fn[0];
        w_dec_write_c       = ~w_alu_fn[2];
        w_dec_write_z       = 1'b1;
        w_dec_alu_in_mux    = w_major[1];
        w_src_a_en          = 1'b1;
        w_src_b_en          = ~w_major[1];
      end
      3'b100: begin
        w_dec_reg_write     = 1'b1;
        w_dec_alu_in_mux    = 1'b1;
        w_dec_reg_write_mux = WB_MEM;
        w_src_a_en          = 1'b1;
      end
      3'b101: begin
        w_dec_mem_write  = 1'b1;
        w_dec_reg_B_mux  = 1'b1;
        w_dec_alu_in_mux = 1'b1;
        w_src_a_en       = 1'b1;
        w_src_b_en       = 1'b1;
        w_src_b          = w_rd;
      end
      3'b110: begin
        w_dec_reg_write     = 1'b1;
        w_dec_reg_write_mux = WB_SHF;
        w_dec_select_flags  = 1'b1;
        w_dec_write_c       = 1'b1;
        w_dec_write_z       = 1'b1;
        w_src_a_en          = 1'b1;
      end
      default: begin
        case (w_sub)
          3'b000: w_dec_pc_mux = PC_ABS;
          3'b001: begin
            w_dec_pc_mux = PC_ABS;
            w_dec_push   = 1'b1;
          end
          3'b010: begin
            w_dec_pc_mux = PC_STK;
            w_dec_pop    = 1'b1;
          end
          3'b011: w_dec_pc_mux = PC_SEQ;
          default: begin
            // sub[1] picks C or Z, sub[0] inverts the sense.
            w_is_cond = 1'b1;
            w_taken   = (w_sub[1] ? C : Z) ^ w_sub[0];
            if (w_taken) w_dec_pc_mux = PC_REL;
          end
        endcase
      end
    endcase
  end

  function automatic logic sb_match(input logic [SB_DEPTH-1:0]            valid,
                                    input logic [SB_DEPTH-1:0][REG_W-1:0] rd,
                                    input logic [REG_W-1:0]               src);
    return (valid[0] && (rd[0] == src)) ||
           (valid[1] && (rd[1] == src)) ||
           (valid[2] && (rd[2] == src));
  endfunction

  assign w_transfer    = (w_dec_pc_mux != PC_SEQ);
  assign w_data_hazard = (w_src_a_en && sb_match(r_sb_valid, r_sb_rd, w_rs)) ||
                         (w_src_b_en && sb_match(r_sb_valid, r_sb_rd, w_src_b));
  assign w_flag_hazard = w_is_cond && r_sb_wflag[0];
  assign w_hazard      = w_data_hazard || w_flag_hazard;

  // Cycle decision: squash/reset bubble, hazard stall, or issue.
  always_comb begin
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    alu_use_carry = 1'b0;
    alu_op        = '0;
    pc_mux        = PC_SEQ;
    reg_write_mux = WB_ALU;
    alu_in_mux    = 1'b0;
    reg_B_mux     = 1'b0;
    select_c      = 1'b0;
    select_z      = 1'b0;
    write_c       = 1'b0;
    write_z       = 1'b0;
    flush         = 1'b0;
    stall         = 1'b0;
    if (!(reset || r_squash)) begin
      if (w_hazard) begin
        stall = 1'b1;
      end else begin
        mem_write     = w_dec_mem_write;
        reg_write     = w_dec_reg_write;
        push          = w_dec_push;
        pop           = w_dec_pop;
        alu_use_carry = w_dec_alu_use_carry;
        alu_op        = w_dec_alu_op;
        pc_mux        = w_dec_pc_mux;
        reg_write_mux = w_dec_reg_write_mux;
        alu_in_mux    = w_dec_alu_in_mux;
        reg_B_mux     = w_dec_reg_B_mux;
        select_c      = w_dec_select_flags;
        select_z      = w_dec_select_flags;
        write_c       = w_dec_write_c;
        write_z       = w_dec_write_z;
        flush         = w_transfer;
      end
    end
  end

  // Scoreboard shifts every cycle; a bubble or stall pushes an invalid entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_squash   <= 1'b1;
      r_sb_valid <= '0;
      r_sb_rd    <= '0;
      r_sb_wflag <= '0;
    end else begin
      r_squash   <= flush;
      r_sb_valid <= {r_sb_valid[SB_DEPTH-2:0], reg_write};
      r_sb_rd    <= {r_sb_rd[SB_DEPTH-2:0], w_rd};
      r_sb_wflag <= {r_sb_wflag[SB_DEPTH-2:0], write_c | write_z};
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed cycle table for the pipe_ctrl decode/hazard unit, then a randomized run
// compared against an issue-history model of the decode and hazard rules.
module tb_pipe_ctrl;

  typedef struct packed {
    logic       mem_write;
    logic       reg_write;
    logic       push;
    logic       pop;
    logic       alu_use_carry;
    logic [2:0] alu_op;
    logic [1:0] pc_mux;
    logic [1:0] reg_write_mux;
    logic       alu_in_mux;
    logic       reg_B_mux;
    logic       select_c;
    logic       select_z;
    logic       write_c;
    logic       write_z;
    logic       flush;
    logic       stall;
  } outs_t;

  typedef struct {
    bit          rst;
    logic [18:0] ins;
    bit          c;
    bit          z;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [18:0] instr;
  logic        C;
  logic        Z;
  logic        mem_write, reg_write, push, pop, alu_use_carry;
  logic [2:0]  alu_op;
  logic [1:0]  pc_mux, reg_write_mux;
  logic        alu_in_mux, reg_B_mux, select_c, select_z, write_c, write_z, flush, stall;
  outs_t       got;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t tbl[$];

  // Model state: cycle index of the most recent issued writer per register / flags.
  int m_last_wr[8];
  int m_last_flag;
  bit m_squash;
  int m_cyc = 0;

  pipe_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .IF_ID_instruction(instr),
    .C                (C),
    .Z                (Z),
    .mem_write        (mem_write),
    .reg_write        (reg_write),
    .push             (push),
    .pop              (pop),
    .alu_use_carry    (alu_use_carry),
    .alu_op           (alu_op),
    .pc_mux           (pc_mux),
    .reg_write_mux    (reg_write_mux),
    .alu_in_mux       (alu_in_mux),
    .reg_B_mux        (reg_B_mux),
    .select_c         (select_c),
    .select_z         (select_z),
    .write_c          (write_c),
    .write_z          (write_z),
    .flush            (flush),
    .stall            (stall)
  );

  always #5 clk = ~clk;

  assign got = {mem_write, reg_write, push, pop, alu_use_carry, alu_op, pc_mux, reg_write_mux,
                alu_in_mux, reg_B_mux, select_c, select_z, write_c, write_z, flush, stall};

  function automatic logic [18:0] enc_r(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [2:0] rt);
    return {2'b00, op, rd, rs, rt, 5'b00000};
  endfunction

  function automatic logic [18:0] enc_i(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs, input logic [7:0] imm);
    return {2'b01, op, rd, rs, imm};
  endfunction

  function automatic logic [18:0] enc_mem(input logic st, input logic [2:0] r,
                                          input logic [2:0] rs, input logic [7:0] imm);
    return {2'b10, st, 2'b00, r, rs, imm};
  endfunction

  function automatic logic [18:0] enc_sh(input logic [2:0] rd, input logic [2:0] rs);
    return {3'b110, 2'b00, rd, rs, 8'h00};
  endfunction

  function automatic logic [18:0] enc_ctl(input logic [2:0] sub, input logic [12:0] tgt);
    return {3'b111, sub, tgt};
  endfunction

  function automatic outs_t e_alu(input logic [2:0] op, input bit carry, input bit imm, input bit wc);
    outs_t o = '0;
    o.reg_write     = 1'b1;
    o.alu_op        = op;
    o.alu_use_carry = carry;
    o.alu_in_mux    = imm;
    o.write_c       = wc;
    o.write_z       = 1'b1;
    return o;
  endfunction

  // Reference decode written straight from the instruction-class table.
  function automatic outs_t spec_decode(input logic [18:0] ins, input bit c, input bit z);
    outs_t o;
    int major, fn, sub;
    o = '0;
    major = int'(ins[18:16]);
    fn    = int'(ins[16:14]);
    sub   = int'(ins[15:13]);
    if (major <= 3) begin
      o.alu_op        = ins[16:14];
      o.reg_write     = 1'b1;
      o.write_z       = 1'b1;
      o.write_c       = (fn < 4);
      o.alu_use_carry = (fn == 1 || fn == 3);
      o.alu_in_mux    = (major >= 2);
    end else if (major == 4) begin
      o.reg_write     = 1'b1;
      o.alu_in_mux    = 1'b1;
      o.reg_write_mux = 2'd2;
    end else if (major == 5) begin
      o.mem_write  = 1'b1;
      o.reg_B_mux  = 1'b1;
      o.alu_in_mux = 1'b1;
    end else if (major == 6) begin
      o.reg_write     = 1'b1;
      o.reg_write_mux = 2'd1;
      o.select_c      = 1'b1;
      o.select_z      = 1'b1;
      o.write_c       = 1'b1;
      o.write_z       = 1'b1;
    end else begin
      case (sub)
        0: o.pc_mux = 2'd2;
        1: begin o.pc_mux = 2'd2; o.push = 1'b1; end
        2: begin o.pc_mux = 2'd3; o.pop = 1'b1; end
        4: if (z)  o.pc_mux = 2'd1;
        5: if (!z) o.pc_mux = 2'd1;
        6: if (c)  o.pc_mux = 2'd1;
        7: if (!c) o.pc_mux = 2'd1;
        default: ;
      endcase
    end
    o.flush = (o.pc_mux != 2'd0);
    return o;
  endfunction

  function automatic bit recent_write(input logic [2:0] r);
    return (m_cyc - m_last_wr[r]) <= 3;
  endfunction

  function automatic bit model_hazard(input logic [18:0] ins);
    int major;
    bit h;
    major = int'(ins[18:16]);
    h = 1'b0;
    if (major != 7 && recent_write(ins[10:8])) h = 1'b1;
    if (major <= 1 && recent_write(ins[7:5])) h = 1'b1;
    if (major == 5 && recent_write(ins[13:11])) h = 1'b1;
    if (major == 7 && ins[15] && (m_cyc - m_last_flag == 1)) h = 1'b1;
    return h;
  endfunction

  function automatic outs_t model_eval(input bit rst, input logic [18:0] ins, input bit c, input bit z);
    outs_t o;
    o = '0;
    if (rst || m_squash) return o;
    if (model_hazard(ins)) begin
      o.stall = 1'b1;
      return o;
    end
    return spec_decode(ins, c, z);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) m_last_wr[r] = -1000;
    m_last_flag = -1000;
    m_squash    = 1'b1;
  endtask

  task automatic model_commit(input bit rst, input logic [18:0] ins, input outs_t o);
    if (rst) begin
      model_reset();
    end else begin
      m_squash = o.flush;
      if (o.reg_write) m_last_wr[ins[13:11]] = m_cyc;
      if (o.write_c || o.write_z) m_last_flag = m_cyc;
    end
    m_cyc++;
  endtask

  task automatic run_cycle(input bit rst, input logic [18:0] ins, input bit c, input bit z,
                           input bit use_tbl, input outs_t tbl_exp, input int idx, output outs_t mexp);
    outs_t exp;
    @(negedge clk);
    reset = rst;
    instr = ins;
    C     = c;
    Z     = z;
    #1;
    mexp = model_eval(rst, ins, c, z);
    exp  = use_tbl ? tbl_exp : mexp;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: instr=%05h rst=%0b C=%0b Z=%0b got=%05h expected=%05h",
               use_tbl ? "vec" : "rand", idx, ins, rst, c, z, got, exp);
    end
    model_commit(rst, ins, mexp);
  endtask

  task automatic add(input bit rst, input logic [18:0] ins, input bit c, input bit z, input outs_t exp);
    vec_t v;
    v.rst = rst;
    v.ins = ins;
    v.c   = c;
    v.z   = z;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    outs_t       B, S, E_BR, E_JSB, E_RET, E_LD, E_ST, E_SH, mexp;
    logic [18:0] ADD123, SUB415, OR467, SUB111, BZ5, NOP, JSB, RET, LD, ST, ADCI, SH, cur;
    bit          r;

    reset = 1'b1;
    instr = '0;
    C     = 1'b0;
    Z     = 1'b0;
    model_reset();

    ADD123 = enc_r(3'd0, 3'd1, 3'd2, 3'd3);
    SUB415 = enc_r(3'd2, 3'd4, 3'd1, 3'd5);
    OR467  = enc_r(3'd5, 3'd4, 3'd6, 3'd7);
    SUB111 = enc_r(3'd2, 3'd1, 3'd1, 3'd1);
    BZ5    = enc_ctl(3'd4, 13'd5);
    NOP    = enc_ctl(3'd3, 13'd0);
    JSB    = enc_ctl(3'd1, 13'h123);
    RET    = enc_ctl(3'd2, 13'd0);
    LD     = enc_mem(1'b0, 3'd2, 3'd1, 8'd4);
    ST     = enc_mem(1'b1, 3'd2, 3'd3, 8'd0);
    ADCI   = enc_i(3'd1, 3'd5, 3'd6, 8'd7);
    SH     = enc_sh(3'd6, 3'd5);

    B = '0;
    S = '0;     S.stall = 1'b1;
    E_BR = '0;  E_BR.pc_mux = 2'd1;  E_BR.flush = 1'b1;
    E_JSB = '0; E_JSB.pc_mux = 2'd2; E_JSB.push = 1'b1; E_JSB.flush = 1'b1;
    E_RET = '0; E_RET.pc_mux = 2'd3; E_RET.pop = 1'b1;  E_RET.flush = 1'b1;
    E_LD = '0;  E_LD.reg_write = 1'b1; E_LD.alu_in_mux = 1'b1; E_LD.reg_write_mux = 2'd2;
    E_ST = '0;  E_ST.mem_write = 1'b1; E_ST.reg_B_mux = 1'b1; E_ST.alu_in_mux = 1'b1;
    E_SH = '0;  E_SH.reg_write = 1'b1; E_SH.reg_write_mux = 2'd1;
    E_SH.select_c = 1'b1; E_SH.select_z = 1'b1; E_SH.write_c = 1'b1; E_SH.write_z = 1'b1;

    // reset, squash cycle, first issue
    add(1'b1, ADD123, 1'b0, 1'b0, B);
    add(1'b1, ADD123, 1'b0, 1'b0, B);
    add(1'b0, ADD123, 1'b0, 1'b0, B);
    add(1'b0, ADD123, 1'b0, 1'b0, e_alu(3'd0, 1'b0, 1'b0, 1'b1));
    // RAW on previous instruction: three stalls
    for (int k = 0; k < 3; k++) add(1'b0, SUB415, 1'b0, 1'b0, S);
    add(1'b0, SUB415, 1'b0, 1'b0, e_alu(3'd2, 1'b0, 1'b0, 1'b1));
    // independent logic op: no stall, Z only
    add(1'b0, ADD123, 1'b0, 1'b0, e_alu(3'd0, 1'b0, 1'b0, 1'b1));
    add(1'b0, OR467,  1'b0, 1'b0, e_alu(3'd5, 1'b0, 1'b0, 1'b0));
    add(1'b0, NOP,    1'b0, 1'b0, B);
    add(1'b0, NOP,    1'b0, 1'b0, B);
    // flag hazard then taken BZ
    add(1'b0, SUB111, 1'b0, 1'b0, e_alu(3'd2, 1'b0, 1'b0, 1'b1));
    add(1'b0, BZ5,    1'b0, 1'b1, S);
    add(1'b0, BZ5,    1'b0, 1'b1, E_BR);
    add(1'b0, 19'h0,  1'b0, 1'b0, B);
    // flag hazard then not-taken BZ
    add(1'b0, SUB111, 1'b0, 1'b0, e_alu(3'd2, 1'b0, 1'b0, 1'b1));
    add(1'b0, BZ5,    1'b0, 1'b0, S);
    add(1'b0, BZ5,    1'b0, 1'b0, B);
    // call and return
    add(1'b0, JSB,    1'b0, 1'b0, E_JSB);
    add(1'b0, 19'h0,  1'b0, 1'b0, B);
    add(1'b0, NOP,    1'b0, 1'b0, B);
    add(1'b0, RET,    1'b0, 1'b0, E_RET);
    add(1'b0, 19'h0,  1'b0, 1'b0, B);
    // load-use on store data register
    add(1'b0, LD, 1'b0, 1'b0, E_LD);
    for (int k = 0; k < 3; k++) add(1'b0, ST, 1'b0, 1'b0, S);
    add(1'b0, ST, 1'b0, 1'b0, E_ST);
    // reset during the stall clears the scoreboard
    add(1'b0, LD, 1'b0, 1'b0, E_LD);
    add(1'b0, ST, 1'b0, 1'b0, S);
    add(1'b1, ST, 1'b0, 1'b0, B);
    add(1'b0, ST, 1'b0, 1'b0, B);
    add(1'b0, ST, 1'b0, 1'b0, E_ST);
    // immediate ADC then shift dependent on it
    add(1'b0, ADCI, 1'b0, 1'b0, e_alu(3'd1, 1'b1, 1'b1, 1'b1));
    for (int k = 0; k < 3; k++) add(1'b0, SH, 1'b0, 1'b0, S);
    add(1'b0, SH, 1'b0, 1'b0, E_SH);

    foreach (tbl[i]) run_cycle(tbl[i].rst, tbl[i].ins, tbl[i].c, tbl[i].z, 1'b1, tbl[i].exp, i, mexp);

    // Randomized run: a stall holds IF_ID, a flush clears it, otherwise fetch a random word.
    for (int k = 0; k < 2; k++) run_cycle(1'b1, 19'h0, 1'b0, 1'b0, 1'b0, '0, k, mexp);
    cur = 19'($urandom);
    for (int k = 0; k < 3000; k++) begin
      r = ($urandom_range(0, 199) == 0);
      run_cycle(r, cur, 1'($urandom), 1'($urandom), 1'b0, '0, k, mexp);
      if (r)               cur = 19'($urandom);
      else if (mexp.stall) cur = cur;
      else if (mexp.flush) cur = '0;
      else                 cur = 19'($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
